rom_port_arbiter: RTL and testbench
===================================

// Module: rom_port_arbiter
// PURPOSE
//  Shares one synchronous read port of the 512x32 boot/program ROM between the
//  instruction-fetch requester (i_*) and the data-bus requester (d_*).
//  Round-robin arbitration, word-aligned address check, one-cycle ROM read sequencing.
//  Sits between the CPU fetch/memory stages and a single ROM port (en/addr/do).
// PARAMETERS
//  ADDR_W   9   ROM word-address width; ROM depth = 2**ADDR_W words
// PORTS
//  clk       in   1       system clock, all state on rising edge
//  rst       in   1       asynchronous, active-high reset
//  i_req     in   1       fetch request; held high until i_rdy or i_err
//  i_addr    in   32      fetch byte address
//  i_rdy     out  1       fetch data valid (1-cycle pulse)
//  i_err     out  1       fetch misaligned-address error (1-cycle pulse)
//  i_data    out  32      fetch read data; valid only while i_rdy
//  d_req     in   1       data request; held high until d_rdy or d_err
//  d_addr    in   32      data byte address
//  d_rdy     out  1       data valid (1-cycle pulse)
//  d_err     out  1       data misaligned-address error (1-cycle pulse)
//  d_data    out  32      data read data; valid only while d_rdy
//  rom_en    out  1       ROM port enable
//  rom_addr  out  ADDR_W  ROM word address
//  rom_do    in   32      ROM registered output; valid the cycle after rom_en edge
//  busy      out  1       high in any state other than IDLE
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, rom_en=0, rom_addr=0, all rdy/err=0,
//    busy=0, owner=I, priority pointer=I (fetch wins first tie).
//  - FSM: IDLE -> ISSUE -> RESP -> IDLE; IDLE -> ERR -> IDLE.
//  - IDLE: at clock edge, if any req is high, pick winner. Only one requesting: it wins.
//    Both requesting: the requester named by the pointer wins. Record owner.
//    Winner addr[1:0]!=0 -> ERR, no ROM access. Else register
//    rom_addr=addr[ADDR_W+1:2] -> ISSUE. Bits above ADDR_W+1 are ignored, so addresses wrap.
//  - ISSUE (1 cycle): rom_en=1. The ROM captures the address at the closing edge. -> RESP.
//  - RESP (1 cycle): rom_en=0. owner_rdy=1. owner_data=rom_do (combinational pass-through).
//    Pointer flips to the non-owner. -> IDLE.
//  - ERR (1 cycle): owner_err=1, owner_data=0. Pointer flips to the non-owner. -> IDLE.
//  - Non-owner rdy/err stay 0. x_data is 0 whenever x_rdy=0.
//  - Latency: req high at edge E0 -> rdy high between E1 and E2. Minimum issue interval is 3 cycles.
//  - A requester must drop req at E2 unless it has a new request.
//    A req still high at E2 is sampled as a new request.
//  - Req changes during ISSUE/RESP/ERR are ignored. No request queueing.
//  - Req dropped before its rdy: the transaction still completes and pulses rdy. No abort.
//  - Reset mid-ISSUE/RESP: the transaction is discarded, no rdy pulse.
//    rom_en drops immediately (asynchronous).
//  - The arbiter issues no writes. The ROM is read-only.
// TESTING
//  1 Load image with word0=32'h080000e8. i_req, i_addr=0 -> ISSUE rom_addr=0, rom_en=1;
//    next cycle i_rdy=1, i_data=32'h080000e8, d_rdy=0.
//  2 i_req and d_req both high from reset, addrs 0x4/0x8 -> fetch served first (rom_addr=1),
//    then data (rom_addr=2). Hold both requests continuously -> strict alternation I,D,I,D.
//  3 d_req, d_addr=32'h6 -> d_err pulse 1 cycle after sampling, d_data=0, rom_en never 1,
//    pointer flips to I.
//  4 i_addr=32'h0000_0804 with ADDR_W=9 -> rom_addr=1 (wrap); i_data equals ROM word 1.
//  5 Assert rst during ISSUE -> rom_en=0 and busy=0 immediately, no i_rdy pulse;
//    after release, pending i_req is re-served normally.
//  6 Random req/addr soak, scoreboard vs ROM model:
//    - exactly one rdy/err per accepted request
//    - never two rdy/err in the same cycle
//    - no requester waits more than 6 cycles while its req is held

Source files
------------

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM read port between the fetch (i_*)
// and data (d_*) requesters. Misaligned requests are answered with an error pulse.
module rom_port_arbiter #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_rdy,
  output logic              i_err,
  output logic [31:0]       i_data,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  output logic              d_rdy,
  output logic              d_err,
  output logic [31:0]       d_data,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_do,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2,
    S_ERR   = 2'd3
  } state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_e              state_q;
  logic                owner_q;
  logic                ptr_q;
  logic                rom_en_q;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic                i_rdy_q, d_rdy_q, i_err_q, d_err_q;

  logic                win_d;
  logic [31:0]         win_addr_d;

  // Upper address bits are deliberately dropped, so accesses wrap over the ROM depth.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2]};

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    win_d = OWN_I;
    if (i_req && d_req) win_d = ptr_q;
    else if (d_req)     win_d = OWN_D;
    win_addr_d = (win_d == OWN_D) ? d_addr : i_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_I;
      ptr_q      <= OWN_I;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      i_rdy_q    <= 1'b0;
      d_rdy_q    <= 1'b0;
      i_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      i_rdy_q <= 1'b0;
      d_rdy_q <= 1'b0;
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_req || d_req) begin
            owner_q <= win_d;
            if (win_addr_d[1:0] != 2'b00) begin
              state_q <= S_ERR;
              if (win_d == OWN_D) d_err_q <= 1'b1;
              else                i_err_q <= 1'b1;
            end else begin
              rom_addr_q <= win_addr_d[ADDR_W+1:2];
              rom_en_q   <= 1'b1;
              state_q    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // ROM latches the address at this edge; its data is valid during RESP.
          rom_en_q <= 1'b0;
          state_q  <= S_RESP;
          if (owner_q == OWN_D) d_rdy_q <= 1'b1;
          else                  i_rdy_q <= 1'b1;
        end
        S_RESP: begin
          ptr_q   <= ~owner_q;
          state_q <= S_IDLE;
        end
        S_ERR: begin
          ptr_q   <= ~owner_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;
  assign busy     = (state_q != S_IDLE);
  assign i_rdy    = i_rdy_q;
  assign d_rdy    = d_rdy_q;
  assign i_err    = i_err_q;
  assign d_err    = d_err_q;
  assign i_data   = i_rdy_q ? rom_do : 32'd0;
  assign d_data   = d_rdy_q ? rom_do : 32'd0;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed and soak bench for rom_port_arbiter against a behavioural synchronous ROM.
module tb_rom_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr;
  logic        i_rdy, i_err, d_rdy, d_err;
  logic [31:0] i_data, d_data;
  logic        rom_en;
  logic [8:0]  rom_addr;
  logic [31:0] rom_do;
  logic        busy;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  rom_port_arbiter #(.ADDR_W(9)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_err(i_err), .i_data(i_data),
    .d_req(d_req), .d_addr(d_addr), .d_rdy(d_rdy), .d_err(d_err), .d_data(d_data),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_do(rom_do), .busy(busy)
  );

  function automatic logic [31:0] romw(input logic [8:0] a);
    return (a == 9'd0) ? 32'h080000e8 : (32'hC0DE_0000 | {23'd0, a});
  endfunction

  always @(posedge clk) if (rom_en) rom_do <= romw(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int seen;
    int got;
    logic [31:0] ia, da;
    int iw, dw, irsp, drsp;
    logic ri, rd;

    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0; rom_do = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_rom_en", rom_en, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_i_rdy", i_rdy, 0);
    chk("rst_d_rdy", d_rdy, 0);
    chk("rst_i_err", i_err, 0);
    chk("rst_d_err", d_err, 0);
    @(negedge clk); rst = 1'b0;

    // single fetch of word 0
    i_req = 1'b1; i_addr = 32'h0;
    @(negedge clk);
    chk("t1_rom_en", rom_en, 1);
    chk("t1_rom_addr", rom_addr, 0);
    chk("t1_busy", busy, 1);
    chk("t1_i_rdy_early", i_rdy, 0);
    @(negedge clk);
    chk("t1_i_rdy", i_rdy, 1);
    chk("t1_i_data", i_data, 32'h080000e8);
    chk("t1_d_rdy", d_rdy, 0);
    chk("t1_rom_en_off", rom_en, 0);
    i_req = 1'b0;
    @(negedge clk);
    chk("t1_i_rdy_pulse", i_rdy, 0);
    chk("t1_i_data_zero", i_data, 0);
    chk("t1_idle", busy, 0);

    // both requesting from reset: fetch first, then strict alternation
    rst = 1'b1;
    i_req = 1'b1; i_addr = 32'h4; d_req = 1'b1; d_addr = 32'h8;
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen < 4; c++) begin
      @(negedge clk);
      if (rom_en) chk("t2_rom_addr", rom_addr, (seen % 2 == 0) ? 1 : 2);
      if (i_rdy || d_rdy) begin
        chk("t2_owner", d_rdy, seen % 2);
        chk("t2_both", i_rdy & d_rdy, 0);
        chk("t2_data", d_rdy ? d_data : i_data, romw((seen % 2 == 1) ? 9'd2 : 9'd1));
        seen++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("t2_count", seen, 4);
    @(negedge clk);

    // fetch leaves pointer at D; D misaligned error must flip it back to I
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    @(negedge clk);
    chk("t3_pre_i_rdy", i_rdy, 1);
    i_req = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h6;
    @(negedge clk);
    chk("t3_d_err", d_err, 1);
    chk("t3_d_data", d_data, 0);
    chk("t3_i_err", i_err, 0);
    chk("t3_rom_en", rom_en, 0);
    chk("t3_busy", busy, 1);
    d_req = 1'b0;
    @(negedge clk);
    chk("t3_d_err_pulse", d_err, 0);
    chk("t3_rom_en_after", rom_en, 0);
    chk("t3_idle", busy, 0);
    i_req = 1'b1; i_addr = 32'h14; d_req = 1'b1; d_addr = 32'h18;
    @(negedge clk);
    chk("t3_tie_rom_addr", rom_addr, 5);
    @(negedge clk);
    chk("t3_tie_i_rdy", i_rdy, 1);
    chk("t3_tie_d_rdy", d_rdy, 0);
    i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t3_d_rom_addr", rom_addr, 6);
    @(negedge clk);
    chk("t3_d_rdy", d_rdy, 1);
    chk("t3_d_data_ok", d_data, romw(9'd6));
    d_req = 1'b0;
    @(negedge clk);

    // address wrap: bits above the ROM index are ignored
    i_req = 1'b1; i_addr = 32'h0000_0804;
    @(negedge clk);
    chk("t4_rom_addr", rom_addr, 1);
    @(negedge clk);
    chk("t4_i_rdy", i_rdy, 1);
    chk("t4_i_data", i_data, romw(9'd1));
    i_req = 1'b0;
    @(negedge clk);

    // reset during ISSUE discards the read
    i_req = 1'b1; i_addr = 32'hC;
    @(negedge clk);
    chk("t5_issue", rom_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rom_en_async", rom_en, 0);
    chk("t5_busy_async", busy, 0);
    @(negedge clk);
    chk("t5_no_rdy", i_rdy, 0);
    rst = 1'b0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (i_rdy) begin
        got = 1;
        chk("t5_data", i_data, romw(9'd3));
        break;
      end
    end
    chk("t5_reserved", got, 1);
    i_req = 1'b0;
    @(negedge clk);

    // random soak with per-requester scoreboards
    ia = '0; da = '0; iw = 0; dw = 0; irsp = 0; drsp = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      ri = 1'b0; rd = 1'b0;
      if ((i_rdy || i_err) && (d_rdy || d_err)) chk("t6_overlap", 1, 0);
      if (i_rdy || i_err) begin
        chk("t6_i_pending", i_req, 1);
        chk("t6_i_kind", i_err, (ia[1:0] != 2'b00));
        if (i_rdy) chk("t6_i_data", i_data, romw(ia[10:2]));
        chk("t6_i_wait", (iw <= 6), 1);
        i_req = 1'b0; iw = 0; irsp++; ri = 1'b1;
      end else if (i_req) begin
        iw++;
        if (iw == 7) chk("t6_i_starved", iw, 6);
      end
      if (d_rdy || d_err) begin
        chk("t6_d_pending", d_req, 1);
        chk("t6_d_kind", d_err, (da[1:0] != 2'b00));
        if (d_rdy) chk("t6_d_data", d_data, romw(da[10:2]));
        chk("t6_d_wait", (dw <= 6), 1);
        d_req = 1'b0; dw = 0; drsp++; rd = 1'b1;
      end else if (d_req) begin
        dw++;
        if (dw == 7) chk("t6_d_starved", dw, 6);
      end
      if (!i_req && !ri && $urandom_range(0, 2) == 0) begin
        ia = $urandom & 32'h0000_0FFF;
        if ($urandom_range(0, 3) != 0) ia[1:0] = 2'b00;
        i_addr = ia; i_req = 1'b1; iw = 0;
      end
      if (!d_req && !rd && $urandom_range(0, 2) == 0) begin
        da = $urandom & 32'h0000_0FFF;
        if ($urandom_range(0, 3) != 0) da[1:0] = 2'b00;
        d_addr = da; d_req = 1'b1; dw = 0;
      end
    end
    chk("t6_i_activity", (irsp > 100), 1);
    chk("t6_d_activity", (drsp > 100), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
